// File: rtl/cache_set.sv
// One set of a set-associative cache: per-way tag/valid/dirty/LRU age and line data,
// combinational lookup and victim selection, and a word-serial line refill engine.
//
// state  | meaning
// S_IDLE | lookups and read/write hits serviced; fill_start begins a refill
// S_FILL | refilling latched way fw one word per fill_valid; lookups report miss
module cache_set #(
    parameter  int TAG_WIDTH  = 20,
    parameter  int LINE_WIDTH = 4,
    parameter  int WAYS       = 4,
    localparam int AW         = $clog2(WAYS),
    localparam int WI         = LINE_WIDTH - 2,
    localparam int WORDS      = 2 ** WI
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [TAG_WIDTH-1:0]  target,
    input  logic [LINE_WIDTH-1:0] index,
    input  logic                  write_en,
    input  logic [3:0]            byte_en,
    input  logic [31:0]           data,
    output logic                  hit,
    output logic [AW-1:0]         hit_way,
    output logic [31:0]           out,
    output logic [AW-1:0]         victim_way,
    output logic                  victim_valid,
    output logic                  victim_dirty,
    output logic [TAG_WIDTH-1:0]  victim_tag,
    input  logic [WI-1:0]         wb_index,
    output logic [31:0]           wb_data,
    input  logic                  fill_start,
    input  logic [TAG_WIDTH-1:0]  fill_tag,
    input  logic                  fill_valid,
    input  logic [31:0]           fill_data,
    output logic                  fill_busy,
    output logic                  fill_done
);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t state, state_next;

    logic                 valid [WAYS];
    logic                 dirty [WAYS];
    logic [TAG_WIDTH-1:0] tag   [WAYS];
    logic [AW-1:0]        age   [WAYS];
    logic [31:0]          mem   [WAYS][WORDS];

    logic [AW-1:0] fw;
    logic [WI-1:0] cnt;

    logic [WI-1:0] word_sel;
    logic          hit_any;
    logic [AW-1:0] hit_idx;
    logic [AW-1:0] victim_live;
    logic          found_invalid;
    logic          start_fill, acc_hit, fill_word, fill_last;
    logic          lru_en;
    logic [AW-1:0] lru_way;
    logic          unused_offset;

    assign word_sel      = index[LINE_WIDTH-1:2];
    assign unused_offset = ^index[1:0];

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid[i] && tag[i] == target) begin
                hit_any = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    assign hit     = hit_any && (state == S_IDLE);
    assign hit_way = hit ? hit_idx : '0;
    assign out     = hit ? mem[hit_idx][word_sel] : 32'h0;

    // Invalid ways are always preferred, lowest index first; otherwise the oldest way.
    always_comb begin
        victim_live   = '0;
        found_invalid = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found_invalid && !valid[i]) begin
                victim_live   = AW'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 0; i < WAYS; i++) begin
                if (age[i] == AW'(WAYS - 1)) victim_live = AW'(i);
            end
        end
    end

    assign victim_way   = (state == S_FILL) ? fw : victim_live;
    assign victim_valid = valid[victim_way];
    assign victim_dirty = dirty[victim_way];
    assign victim_tag   = tag[victim_way];
    assign wb_data      = mem[victim_way][wb_index];
    assign fill_busy    = (state == S_FILL);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_fill = 1'b0;
        acc_hit    = 1'b0;
        fill_word  = 1'b0;
        fill_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fill_start) begin
                    start_fill = 1'b1;
                    state_next = S_FILL;
                end else if (en && hit) begin
                    acc_hit = 1'b1;
                end
            end
            S_FILL: begin
                if (fill_valid) begin
                    fill_word = 1'b1;
                    if (cnt == WI'(WORDS - 1)) begin
                        fill_last  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        lru_en  = acc_hit || fill_last;
        lru_way = fill_last ? fw : hit_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                valid[i] <= 1'b0;
                dirty[i] <= 1'b0;
                tag[i]   <= '0;
                age[i]   <= AW'(WAYS - 1 - i);
                for (int j = 0; j < WORDS; j++) mem[i][j] <= 32'h0;
            end
            fw        <= '0;
            cnt       <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= fill_last;
            if (start_fill) begin
                fw                 <= victim_live;
                tag[victim_live]   <= fill_tag;
                valid[victim_live] <= 1'b0;
                dirty[victim_live] <= 1'b0;
                cnt                <= '0;
            end
            if (fill_word) begin
                mem[fw][cnt] <= fill_data;
                cnt          <= cnt + WI'(1);
                if (fill_last) valid[fw] <= 1'b1;
            end
            if (acc_hit && write_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) mem[hit_idx][word_sel][8*b +: 8] <= data[8*b +: 8];
                end
                dirty[hit_idx] <= 1'b1;
            end
            // Ages younger than the touched way shift up by one, keeping a permutation.
            if (lru_en) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (AW'(i) == lru_way)        age[i] <= '0;
                    else if (age[i] < age[lru_way]) age[i] <= age[i] + AW'(1);
                end
            end
        end
    end

endmodule
